risc16_dual_port_memory: RTL and testbench

- Parametrised successor to the single-port RiSC-16 word memory.
- Two ports: a read-only instruction port (fetch) and a read/write data port (load/store). Both use request/ready handshakes, a configurable registered read latency and posedge timing.
- After reset, an optional clear FSM zeroes the array one word per cycle, replacing the old single-cycle loop.
- Sits between the pipelined RiSC-16 core's fetch/memory stages and the word-addressed memory space.

---
 rtl/risc16_dual_port_memory_pkg.sv | 18 +
 rtl/risc16_dual_port_memory_if.sv | 34 +++
 rtl/risc16_valid_pipe.sv | 43 ++++
 rtl/risc16_dual_port_memory.sv | 129 ++++++++++++
 tb/tb_risc16_dual_port_memory.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/risc16_dual_port_memory_pkg.sv
// Shared definitions for the dual-port RiSC-16 word memory: controller
// state encodings and the legal range for the registered read latency.
package risc16_dual_port_memory_pkg;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_CLEAR = 2'd1,
        ST_READY = 2'd2
    } memState_e;

    localparam int MIN_READ_LATENCY = 1;
    localparam int MAX_READ_LATENCY = 4;

    function automatic bit readLatencyLegal(input int latency);
        return (latency >= MIN_READ_LATENCY) && (latency <= MAX_READ_LATENCY);
    endfunction

endpackage

// File: rtl/risc16_dual_port_memory_if.sv
// Bus bundle between the RiSC-16 core (master) and the dual-port word
// memory (slave): an instruction fetch port and a load/store data port.
interface risc16_dual_port_memory_if #(
    parameter int ADDR_WIDTH  = 16,
    parameter int WORD_LENGTH = 16
);

    logic                   busy;

    logic                   iReq;
    logic [ADDR_WIDTH-1:0]  iAddress;
    logic                   iReady;
    logic                   iValid;
    logic [WORD_LENGTH-1:0] iDataOut;

    logic                   dReq;
    logic                   dWriteEn;
    logic [ADDR_WIDTH-1:0]  dAddress;
    logic [WORD_LENGTH-1:0] dDataIn;
    logic                   dReady;
    logic                   dValid;
    logic [WORD_LENGTH-1:0] dDataOut;

    modport master (
        output iReq, iAddress, dReq, dWriteEn, dAddress, dDataIn,
        input  busy, iReady, iValid, iDataOut, dReady, dValid, dDataOut
    );

    modport slave (
        input  iReq, iAddress, dReq, dWriteEn, dAddress, dDataIn,
        output busy, iReady, iValid, iDataOut, dReady, dValid, dDataOut
    );

endinterface

// File: rtl/risc16_valid_pipe.sv
// LATENCY-deep shift of {valid, data} used to delay a read result by the
// configured read latency. Data stages only load on a valid beat, so the
// final stage holds the last returned word while valid is low.
module risc16_valid_pipe #(
    parameter int LATENCY = 1,
    parameter int WIDTH   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             validIn_i,
    input  logic [WIDTH-1:0] dataIn_i,
    output logic             validOut_o,
    output logic [WIDTH-1:0] dataOut_o
);

    logic [LATENCY-1:0] valid_q;
    logic [WIDTH-1:0]   data_q [LATENCY];

    // Advance valid every cycle; move data only alongside a valid beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q[0] <= validIn_i;
            if (validIn_i) begin
                data_q[0] <= dataIn_i;
            end
            for (int k = 1; k < LATENCY; k++) begin
                valid_q[k] <= valid_q[k-1];
                if (valid_q[k-1]) begin
                    data_q[k] <= data_q[k-1];
                end
            end
        end
    end

    assign validOut_o = valid_q[LATENCY-1];
    assign dataOut_o  = data_q[LATENCY-1];

endmodule

// File: rtl/risc16_dual_port_memory.sv
// Dual-port RiSC-16 word memory: read-only instruction port plus a
// read/write data port, both with registered read latency. After reset an
// optional clear sequence zeroes one word per cycle before accepting traffic.
module risc16_dual_port_memory
    import risc16_dual_port_memory_pkg::*;
#(
    parameter int WORD_LENGTH    = 16,
    parameter int ADDR_WIDTH     = 16,
    parameter int READ_LATENCY   = 1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    risc16_dual_port_memory_if.slave  memBus
);

    localparam int MEM_SIZE = 2 ** ADDR_WIDTH;

    if (!readLatencyLegal(READ_LATENCY)) begin : gBadReadLatency
        $error("risc16_dual_port_memory: READ_LATENCY must be within 1..4");
    end

    memState_e               state_q, state_d;
    logic [ADDR_WIDTH:0]     counter_q, counter_d, counterInc;
    logic [WORD_LENGTH-1:0]  memArray [MEM_SIZE];

    logic                    busy;
    logic                    clearing;
    logic                    iAccept;
    logic                    dReadAccept;
    logic                    dWriteAccept;
    logic [WORD_LENGTH-1:0]  iReadWord;
    logic [WORD_LENGTH-1:0]  dReadWord;

    assign busy     = (state_q != ST_READY);
    assign clearing = (state_q == ST_CLEAR);

    // The extra counter bit flags the increment past the last word.
    assign counterInc = counter_q + {{ADDR_WIDTH{1'b0}}, 1'b1};

    // Requests are only taken when ready, and never on a reset edge.
    assign iAccept      = memBus.iReq && !busy && !rst;
    assign dReadAccept  = memBus.dReq && !memBus.dWriteEn && !busy && !rst;
    assign dWriteAccept = memBus.dReq &&  memBus.dWriteEn && !busy && !rst;

    // Controller state and clear counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RESET;
            counter_q <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
        end
    end

    // Next-state logic: leave reset into clear or ready, walk the array
    // while clearing, and return the counter to zero once done.
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        case (state_q)
            ST_RESET: begin
                counter_d = '0;
                if (CLEAR_ON_RESET) begin
                    state_d = ST_CLEAR;
                end else begin
                    state_d = ST_READY;
                end
            end
            ST_CLEAR: begin
                counter_d = counterInc;
                if (counterInc[ADDR_WIDTH]) begin
                    counter_d = '0;
                    state_d   = ST_READY;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

    // Single write port shared by the clear walk and data-port stores.
    always_ff @(posedge clk) begin
        if (clearing && !rst) begin
            memArray[counter_q[ADDR_WIDTH-1:0]] <= '0;
        end else if (dWriteAccept) begin
            memArray[memBus.dAddress] <= memBus.dDataIn;
        end
    end

    // Reads sample the array before this edge's write lands, which gives
    // read-before-write on an instruction/data collision.
    assign iReadWord = memArray[memBus.iAddress];
    assign dReadWord = memArray[memBus.dAddress];

    risc16_valid_pipe #(
        .LATENCY (READ_LATENCY),
        .WIDTH   (WORD_LENGTH)
    ) uIPipe (
        .clk        (clk),
        .rst        (rst),
        .validIn_i  (iAccept),
        .dataIn_i   (iReadWord),
        .validOut_o (memBus.iValid),
        .dataOut_o  (memBus.iDataOut)
    );

    risc16_valid_pipe #(
        .LATENCY (READ_LATENCY),
        .WIDTH   (WORD_LENGTH)
    ) uDPipe (
        .clk        (clk),
        .rst        (rst),
        .validIn_i  (dReadAccept),
        .dataIn_i   (dReadWord),
        .validOut_o (memBus.dValid),
        .dataOut_o  (memBus.dDataOut)
    );

    assign memBus.busy   = busy;
    assign memBus.iReady = !busy;
    assign memBus.dReady = !busy;

endmodule

// File: tb/tb_risc16_dual_port_memory.sv
// Randomised bench for the dual-port word memory against a word-array
// reference with per-port queues of expected read returns.
module tb_risc16_dual_port_memory;

    localparam int AW       = 4;
    localparam int WL       = 16;
    localparam int LAT      = 2;
    localparam int MEM_SIZE = 16;
    // One cycle in reset state, then one cycle per cleared word.
    localparam int CLEAR_BUSY_CYCLES = 1 + MEM_SIZE;

    logic clk = 1'b0;
    logic rst;
    logic rstNc;

    always #5 clk = ~clk;

    risc16_dual_port_memory_if #(.ADDR_WIDTH(AW), .WORD_LENGTH(WL)) memBus ();
    risc16_dual_port_memory_if #(.ADDR_WIDTH(AW), .WORD_LENGTH(WL)) ncBus ();

    risc16_dual_port_memory #(
        .WORD_LENGTH(WL), .ADDR_WIDTH(AW), .READ_LATENCY(LAT), .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .memBus (memBus)
    );

    risc16_dual_port_memory #(
        .WORD_LENGTH(WL), .ADDR_WIDTH(AW), .READ_LATENCY(LAT), .CLEAR_ON_RESET(1'b0)
    ) dutNc (
        .clk    (clk),
        .rst    (rstNc),
        .memBus (ncBus)
    );

    typedef struct {
        int            due;
        logic [WL-1:0] data;
    } readExp_t;

    int            vectors     = 0;
    int            miscompares = 0;
    int            cyc         = 0;
    int            busyLeft    = 0;
    readExp_t      iQ[$];
    readExp_t      dQ[$];
    logic [WL-1:0] refMem [MEM_SIZE];
    logic [WL-1:0] lastI = '0;
    logic [WL-1:0] lastD = '0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h",
                     tag, cyc, observed, expected);
        end
    endtask

    // Reference behaviour at one rising edge with the given inputs.
    task automatic modelEdge(input logic r, input logic iq, input logic [AW-1:0] ia,
                             input logic dq, input logic dw, input logic [AW-1:0] da,
                             input logic [WL-1:0] dd);
        bit readyNow;
        readyNow = (busyLeft == 0);
        if (r) begin
            iQ.delete();
            dQ.delete();
            lastI    = '0;
            lastD    = '0;
            busyLeft = CLEAR_BUSY_CYCLES;
            for (int a = 0; a < MEM_SIZE; a++) refMem[a] = '0;
        end else begin
            if (busyLeft > 0) busyLeft--;
            if (readyNow) begin
                if (iq) iQ.push_back(readExp_t'{cyc + LAT - 1, refMem[ia]});
                if (dq && !dw) dQ.push_back(readExp_t'{cyc + LAT - 1, refMem[da]});
                if (dq && dw) refMem[da] = dd;
            end
        end
    endtask

    task automatic checkCycle();
        logic expIV;
        logic expDV;
        logic expBusy;
        expIV = 1'b0;
        expDV = 1'b0;
        if (iQ.size() > 0 && iQ[0].due == cyc) begin
            expIV = 1'b1;
            lastI = iQ[0].data;
            void'(iQ.pop_front());
        end
        if (dQ.size() > 0 && dQ[0].due == cyc) begin
            expDV = 1'b1;
            lastD = dQ[0].data;
            void'(dQ.pop_front());
        end
        expBusy = (busyLeft > 0);
        checkOutput("busy",     32'(memBus.busy),     32'(expBusy));
        checkOutput("iReady",   32'(memBus.iReady),   32'(!expBusy));
        checkOutput("dReady",   32'(memBus.dReady),   32'(!expBusy));
        checkOutput("iValid",   32'(memBus.iValid),   32'(expIV));
        checkOutput("iDataOut", 32'(memBus.iDataOut), 32'(lastI));
        checkOutput("dValid",   32'(memBus.dValid),   32'(expDV));
        checkOutput("dDataOut", 32'(memBus.dDataOut), 32'(lastD));
    endtask

    // Drive one cycle from the falling edge, model the rising edge, check
    // at the next falling edge.
    task automatic applyStimulus(input logic r, input logic iq, input logic [AW-1:0] ia,
                                 input logic dq, input logic dw, input logic [AW-1:0] da,
                                 input logic [WL-1:0] dd);
        rst             = r;
        memBus.iReq     = iq;
        memBus.iAddress = ia;
        memBus.dReq     = dq;
        memBus.dWriteEn = dw;
        memBus.dAddress = da;
        memBus.dDataIn  = dd;
        @(posedge clk);
        cyc++;
        modelEdge(r, iq, ia, dq, dw, da, dd);
        @(negedge clk);
        checkCycle();
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic randomStep(input logic r);
        applyStimulus(r, 1'($urandom), AW'($urandom), 1'($urandom), 1'($urandom),
                      AW'($urandom), WL'($urandom));
    endtask

    initial begin
        rst             = 1'b1;
        rstNc           = 1'b1;
        memBus.iReq     = 1'b0;
        memBus.iAddress = '0;
        memBus.dReq     = 1'b0;
        memBus.dWriteEn = 1'b0;
        memBus.dAddress = '0;
        memBus.dDataIn  = '0;
        ncBus.iReq      = 1'b0;
        ncBus.iAddress  = '0;
        ncBus.dReq      = 1'b0;
        ncBus.dWriteEn  = 1'b0;
        ncBus.dAddress  = '0;
        ncBus.dDataIn   = '0;
        @(negedge clk);

        // Power-up reset, then wait out the clear walk.
        applyStimulus(1'b1, 1'b1, 4'd1, 1'b1, 1'b1, 4'd1, 16'hFFFF);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        while (busyLeft > 0) randomStep(1'b0);

        // Random preload of every word with interleaved fetches.
        for (int a = 0; a < MEM_SIZE; a++) begin
            applyStimulus(1'b0, 1'($urandom), AW'($urandom), 1'b1, 1'b1, AW'(a), WL'($urandom));
        end
        idle();
        idle();

        // Reset after preload; requests during busy must vanish; then every
        // word reads back as zero on both ports.
        randomStep(1'b1);
        while (busyLeft > 0) randomStep(1'b0);
        for (int a = 0; a < MEM_SIZE; a++) begin
            applyStimulus(1'b0, 1'b1, AW'(a), 1'b1, 1'b0, AW'(MEM_SIZE - 1 - a), '0);
        end
        repeat (3) idle();

        // Store then load of the same word on the following cycle.
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1, 4'd3, 16'hBEEF);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 4'd3, '0);
        repeat (3) idle();

        // Fetch and store to the same word on one edge: fetch sees old data.
        applyStimulus(1'b0, 1'b1, 4'd5, 1'b1, 1'b1, 4'd5, 16'h1234);
        applyStimulus(1'b0, 1'b1, 4'd5, 1'b0, 1'b0, '0, '0);
        repeat (3) idle();

        // Back-to-back fetches return in order on consecutive cycles.
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1, 4'd0, 16'h000A);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1, 4'd1, 16'h000B);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1, 4'd2, 16'h000C);
        applyStimulus(1'b0, 1'b1, 4'd0, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b0, 1'b1, 4'd1, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b0, 1'b1, 4'd2, 1'b0, 1'b0, '0, '0);
        repeat (3) idle();

        // Reset again part way through the clear walk.
        randomStep(1'b1);
        repeat (8) randomStep(1'b0);
        randomStep(1'b1);
        while (busyLeft > 0) randomStep(1'b0);

        // Random traffic on both ports.
        repeat (400) randomStep(1'b0);
        repeat (4) idle();

        // Instance without clear: contents survive reset.
        @(posedge clk);
        @(negedge clk);
        checkOutput("nc reset busy",     32'(ncBus.busy),     32'd1);
        checkOutput("nc reset iValid",   32'(ncBus.iValid),   32'd0);
        checkOutput("nc reset dValid",   32'(ncBus.dValid),   32'd0);
        checkOutput("nc reset dDataOut", 32'(ncBus.dDataOut), 32'd0);
        rstNc = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("nc ready busy",   32'(ncBus.busy),   32'd0);
        checkOutput("nc ready dReady", 32'(ncBus.dReady), 32'd1);
        ncBus.dReq     = 1'b1;
        ncBus.dWriteEn = 1'b1;
        ncBus.dAddress = 4'd9;
        ncBus.dDataIn  = 16'h55AA;
        @(posedge clk);
        @(negedge clk);
        ncBus.dReq = 1'b0;
        checkOutput("nc write no dValid", 32'(ncBus.dValid), 32'd0);
        rstNc = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rstNc = 1'b0;
        checkOutput("nc rst busy", 32'(ncBus.busy), 32'd1);
        @(posedge clk);
        @(negedge clk);
        checkOutput("nc rst released busy", 32'(ncBus.busy), 32'd0);
        ncBus.dReq     = 1'b1;
        ncBus.dWriteEn = 1'b0;
        ncBus.dAddress = 4'd9;
        @(posedge clk);
        @(negedge clk);
        ncBus.dReq = 1'b0;
        checkOutput("nc read early dValid", 32'(ncBus.dValid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("nc read dValid",   32'(ncBus.dValid),   32'd1);
        checkOutput("nc read dDataOut", 32'(ncBus.dDataOut), 32'h55AA);
        @(posedge clk);
        @(negedge clk);
        checkOutput("nc hold dValid",   32'(ncBus.dValid),   32'd0);
        checkOutput("nc hold dDataOut", 32'(ncBus.dDataOut), 32'h55AA);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
